// File: rtl/wb_sram_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : wb_sram_pkg                                                  |
// | Description : Shared types and constants for the Wishbone SRAM responder:  |
// |               FSM state encoding, byte-to-word address shift and the       |
// |               width of the access wait counter.                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package wb_sram_pkg;

  // Responder FSM states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WRITE = 3'd2,
    WHOLD = 3'd3,
    DONE  = 3'd4
  } state_e;

  // Wishbone byte address -> SRAM word address.
  localparam int WORD_SHIFT = 2;

  // Wait counter width; WAIT_CYCLES must stay within 1..15.
  localparam int WAIT_CNT_W = 4;

endpackage : wb_sram_pkg
`default_nettype wire

// File: rtl/wb_sram_rdbuf.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : wb_sram_rdbuf                                                |
// | Description : One-entry read buffer (valid, word-address tag, data) with a |
// |               byte-merge write port, used to short-circuit repeat reads.   |
// | Ports       : clk_i, rst_i        clock / sync active-high reset           |
// |               clr_i               invalidate the entry                     |
// |               fill_i/_tag/_data   load a fresh word after an SRAM read     |
// |               merge_i/_tag/_data/_sel  byte-merge a write into a hit entry |
// |               lookup_tag_i        tag compared for hit_o                   |
// |               hit_o, data_o       lookup result and buffered word          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module wb_sram_rdbuf
  import wb_sram_pkg::*;
#(
  parameter int TAG_WIDTH  = 20,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clr_i,
  input  logic                    fill_i,
  input  logic [TAG_WIDTH-1:0]    fill_tag_i,
  input  logic [DATA_WIDTH-1:0]   fill_data_i,
  input  logic                    merge_i,
  input  logic [TAG_WIDTH-1:0]    merge_tag_i,
  input  logic [DATA_WIDTH-1:0]   merge_data_i,
  input  logic [DATA_WIDTH/8-1:0] merge_sel_i,
  input  logic [TAG_WIDTH-1:0]    lookup_tag_i,
  output logic                    hit_o,
  output logic [DATA_WIDTH-1:0]   data_o
);

  localparam int C_NUM_BYTES = DATA_WIDTH / 8;

  logic                  valid_q, valid_d;
  logic [TAG_WIDTH-1:0]  tag_q,   tag_d;
  logic [DATA_WIDTH-1:0] data_q,  data_d;

  // Clear wins over fill so an aborted access can never leave a stale entry.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (clr_i) begin
      valid_d = 1'b0;
    end else if (fill_i) begin
      valid_d = 1'b1;
      tag_d   = fill_tag_i;
      data_d  = fill_data_i;
    end else if (merge_i && valid_q && (merge_tag_i == tag_q)) begin
      for (int b = 0; b < C_NUM_BYTES; b++) begin
        if (merge_sel_i[b]) begin
          data_d[8*b +: 8] = merge_data_i[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

  assign hit_o  = valid_q && (tag_q == lookup_tag_i);
  assign data_o = data_q;

endmodule : wb_sram_rdbuf
`default_nettype wire

// File: rtl/wb_sram_responder.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : wb_sram_responder                                            |
// | Description : Wishbone classic-cycle responder driving one asynchronous    |
// |               SRAM bank (shared data bus, active-low controls, byte        |
// |               enables). Read latency WAIT_CYCLES+1, write WAIT_CYCLES+2.   |
// | Ports       : clk_i, rst_i                 clock / sync active-high reset  |
// |               wb_cyc_i..wb_we_i, wb_ack_o, wb_dat_o   Wishbone slave side  |
// |               sram_addr, sram_data (inout), sram_ce_n, sram_oe_n,          |
// |               sram_we_n, sram_be_n          SRAM side                      |
// | Option      : WB_SRAM_RDBUF_EN - one-entry read buffer; read hits ack one  |
// |               cycle after accept without touching the SRAM.                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module wb_sram_responder
  import wb_sram_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int SRAM_ADDR_WIDTH = 20,
  parameter int SRAM_DATA_WIDTH = 32,
  parameter int WAIT_CYCLES     = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         wb_cyc_i,
  input  logic                         wb_stb_i,
  output logic                         wb_ack_o,
  input  logic [ADDR_WIDTH-1:0]        wb_adr_i,
  input  logic [DATA_WIDTH-1:0]        wb_dat_i,
  output logic [DATA_WIDTH-1:0]        wb_dat_o,
  input  logic [DATA_WIDTH/8-1:0]      wb_sel_i,
  input  logic                         wb_we_i,
  output logic [SRAM_ADDR_WIDTH-1:0]   sram_addr,
  inout  wire  [SRAM_DATA_WIDTH-1:0]   sram_data,
  output logic                         sram_ce_n,
  output logic                         sram_oe_n,
  output logic                         sram_we_n,
  output logic [SRAM_DATA_WIDTH/8-1:0] sram_be_n
);

  localparam logic [WAIT_CNT_W-1:0] c_cnt_load = WAIT_CNT_W'(WAIT_CYCLES - 1);
  localparam logic [WAIT_CNT_W-1:0] c_cnt_one  = WAIT_CNT_W'(1);

  state_e                       state_q, state_d;
  logic [WAIT_CNT_W-1:0]        cnt_q, cnt_d;
  logic [SRAM_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]        wdata_q, wdata_d;
  logic [DATA_WIDTH/8-1:0]      sel_q, sel_d;
  logic [DATA_WIDTH-1:0]        rdata_q, rdata_d;
  logic                         abort_q, abort_d;
  logic                         ack_q;
  logic                         ce_n_q, oe_n_q, we_n_q, drive_en_q;
  logic [SRAM_DATA_WIDTH/8-1:0] be_n_q;

  logic                         w_accept;
  logic                         w_abort;
  logic                         w_sram_active;
  logic                         w_drive;
  logic [SRAM_ADDR_WIDTH-1:0]   w_req_addr;
  logic                         w_buf_hit;
  logic [DATA_WIDTH-1:0]        w_buf_data;
  logic                         w_buf_fill;
  logic                         w_buf_clr;
  logic                         w_buf_merge;
  logic                         w_unused_adr;

  // Only the word-address bits reach the SRAM; the rest are don't-care.
  assign w_req_addr   = wb_adr_i[SRAM_ADDR_WIDTH+WORD_SHIFT-1:WORD_SHIFT];
  assign w_unused_adr = ^wb_adr_i;

  assign w_accept = (state_q == IDLE) && wb_cyc_i && wb_stb_i && !ack_q;
  // Once the master drops cyc the access still runs to completion, but the
  // ack is suppressed; the sticky flag remembers a drop that has recovered.
  assign w_abort  = abort_q || !wb_cyc_i;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    sel_d       = sel_q;
    rdata_d     = rdata_q;
    abort_d     = abort_q;
    w_buf_fill  = 1'b0;
    w_buf_clr   = 1'b0;
    w_buf_merge = 1'b0;
    case (state_q)
      IDLE: begin
        if (w_accept) begin
          addr_d  = w_req_addr;
          wdata_d = wb_dat_i;
          sel_d   = wb_sel_i;
          cnt_d   = c_cnt_load;
          abort_d = 1'b0;
          if (wb_we_i) begin
            state_d     = WRITE;
            w_buf_merge = 1'b1;
          end else if (w_buf_hit) begin
            state_d = DONE;
            rdata_d = w_buf_data;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        abort_d = w_abort;
        if (cnt_q == '0) begin
          rdata_d = sram_data;
          if (w_abort) begin
            state_d   = IDLE;
            w_buf_clr = 1'b1;
          end else begin
            state_d    = DONE;
            w_buf_fill = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - c_cnt_one;
        end
      end
      WRITE: begin
        abort_d = w_abort;
        if (cnt_q == '0) begin
          state_d = WHOLD;
        end else begin
          cnt_d = cnt_q - c_cnt_one;
        end
      end
      WHOLD: begin
        if (w_abort) begin
          state_d   = IDLE;
          w_buf_clr = 1'b1;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // SRAM strobes are decoded from the next state and registered so the
  // external pins are glitch-free and line up with the state they belong to.
  assign w_sram_active = (state_d == READ) || (state_d == WRITE) || (state_d == WHOLD);
  assign w_drive       = (state_d == WRITE) || (state_d == WHOLD);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      sel_q      <= '0;
      rdata_q    <= '0;
      abort_q    <= 1'b0;
      ack_q      <= 1'b0;
      ce_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      we_n_q     <= 1'b1;
      be_n_q     <= '1;
      drive_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      sel_q      <= sel_d;
      rdata_q    <= rdata_d;
      abort_q    <= abort_d;
      ack_q      <= (state_d == DONE);
      ce_n_q     <= !w_sram_active;
      oe_n_q     <= (state_d != READ);
      we_n_q     <= (state_d != WRITE);
      be_n_q     <= w_sram_active ? ~sel_d : '1;
      drive_en_q <= w_drive;
    end
  end

`ifdef WB_SRAM_RDBUF_EN
  wb_sram_rdbuf #(
    .TAG_WIDTH  (SRAM_ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rdbuf (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clr_i        (w_buf_clr),
    .fill_i       (w_buf_fill),
    .fill_tag_i   (addr_q),
    .fill_data_i  (sram_data),
    .merge_i      (w_buf_merge),
    .merge_tag_i  (w_req_addr),
    .merge_data_i (wb_dat_i),
    .merge_sel_i  (wb_sel_i),
    .lookup_tag_i (w_req_addr),
    .hit_o        (w_buf_hit),
    .data_o       (w_buf_data)
  );
`else
  logic w_unused_buf;
  assign w_buf_hit    = 1'b0;
  assign w_buf_data   = '0;
  assign w_unused_buf = w_buf_fill ^ w_buf_clr ^ w_buf_merge;
`endif

  assign wb_ack_o  = ack_q;
  assign wb_dat_o  = rdata_q;
  assign sram_addr = addr_q;
  assign sram_ce_n = ce_n_q;
  assign sram_oe_n = oe_n_q;
  assign sram_we_n = we_n_q;
  assign sram_be_n = be_n_q;
  assign sram_data = drive_en_q ? wdata_q : 'z;

endmodule : wb_sram_responder
`default_nettype wire
